// File: rtl/hdmi_vtc_ctrl.sv
// Video timing controller: free-running ppl/lpf counters, sync/DE strobes and the active format.
// Format changes are accepted via valid/ready and applied only on a frame boundary.
module hdmi_vtc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fmt_req_vld,
  output logic        fmt_req_rdy,
  input  logic [2:0]  fmt_req,
  input  logic [11:0] h_total,
  input  logic [11:0] h_sync,
  input  logic [11:0] h_blank,
  input  logic [11:0] v_total,
  input  logic [11:0] v_sync,
  input  logic [11:0] v_blank,
  output logic [2:0]  fmt_def,
  output logic [11:0] ppl,
  output logic [11:0] lpf,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        sof,
  output logic        fmt_ack,
  output logic        fmt_err
);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  state_e      state_q, state_d;
  logic [11:0] ppl_q, ppl_d, lpf_q, lpf_d;
  logic [2:0]  fmt_q, fmt_d;
  logic [11:0] ht_q, ht_d, hs_q, hs_d, hb_q, hb_d;
  logic [11:0] vt_q, vt_d, vs_q, vs_d, vb_q, vb_d;
  logic [2:0]  sh_fmt_q, sh_fmt_d;
  logic [11:0] sh_ht_q, sh_ht_d, sh_hs_q, sh_hs_d, sh_hb_q, sh_hb_d;
  logic [11:0] sh_vt_q, sh_vt_d, sh_vs_q, sh_vs_d, sh_vb_q, sh_vb_d;
  logic        rdy_q, rdy_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, sof_q, sof_d;
  logic        ack_q, ack_d, err_q, err_d;

  logic        accept, req_ok, line_end, frame_end, run_d;
  logic [11:0] adv_ppl, adv_lpf;

  always_comb begin
    accept    = fmt_req_vld && rdy_q;
    req_ok    = (h_total > h_blank) && (v_total > v_blank) && (h_sync <= h_blank) &&
                (v_sync <= v_blank) && (h_sync != 12'd0) && (v_sync != 12'd0);
    line_end  = (ppl_q == ht_q);
    frame_end = line_end && (lpf_q == vt_q);
    adv_ppl   = line_end ? 12'd1 : ppl_q + 12'd1;
    adv_lpf   = lpf_q;
    if (line_end) adv_lpf = frame_end ? 12'd1 : lpf_q + 12'd1;

    state_d  = state_q;
    ppl_d    = ppl_q;
    lpf_d    = lpf_q;
    fmt_d    = fmt_q;
    ht_d     = ht_q;
    hs_d     = hs_q;
    hb_d     = hb_q;
    vt_d     = vt_q;
    vs_d     = vs_q;
    vb_d     = vb_q;
    sh_fmt_d = sh_fmt_q;
    sh_ht_d  = sh_ht_q;
    sh_hs_d  = sh_hs_q;
    sh_hb_d  = sh_hb_q;
    sh_vt_d  = sh_vt_q;
    sh_vs_d  = sh_vs_q;
    sh_vb_d  = sh_vb_q;
    ack_d    = 1'b0;
    err_d    = accept && !req_ok;

    unique case (state_q)
      StIdle: begin
        // From idle there is no frame in flight, so the request applies immediately.
        if (accept && req_ok) begin
          state_d = StRun;
          fmt_d   = fmt_req;
          ht_d    = h_total;
          hs_d    = h_sync;
          hb_d    = h_blank;
          vt_d    = v_total;
          vs_d    = v_sync;
          vb_d    = v_blank;
          ppl_d   = 12'd1;
          lpf_d   = 12'd1;
          ack_d   = 1'b1;
        end
      end
      StRun: begin
        ppl_d = adv_ppl;
        lpf_d = adv_lpf;
        if (accept && req_ok) begin
          state_d  = StPend;
          sh_fmt_d = fmt_req;
          sh_ht_d  = h_total;
          sh_hs_d  = h_sync;
          sh_hb_d  = h_blank;
          sh_vt_d  = v_total;
          sh_vs_d  = v_sync;
          sh_vb_d  = v_blank;
        end
      end
      StPend: begin
        ppl_d = adv_ppl;
        lpf_d = adv_lpf;
        if (frame_end) begin
          state_d = StRun;
          fmt_d   = sh_fmt_q;
          ht_d    = sh_ht_q;
          hs_d    = sh_hs_q;
          hb_d    = sh_hb_q;
          vt_d    = sh_vt_q;
          vs_d    = sh_vs_q;
          vb_d    = sh_vb_q;
          ppl_d   = 12'd1;
          lpf_d   = 12'd1;
          ack_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes use next-state counters and timing so they line up with ppl/lpf.
    run_d   = (state_d != StIdle);
    hsync_d = run_d && (ppl_d <= hs_d);
    vsync_d = run_d && (lpf_d <= vs_d);
    de_d    = run_d && (ppl_d > hb_d) && (lpf_d > vb_d);
    sof_d   = run_d && (ppl_d == 12'd1) && (lpf_d == 12'd1);
    rdy_d   = (state_d != StPend);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ppl_q    <= '0;
      lpf_q    <= '0;
      fmt_q    <= '0;
      ht_q     <= '0;
      hs_q     <= '0;
      hb_q     <= '0;
      vt_q     <= '0;
      vs_q     <= '0;
      vb_q     <= '0;
      sh_fmt_q <= '0;
      sh_ht_q  <= '0;
      sh_hs_q  <= '0;
      sh_hb_q  <= '0;
      sh_vt_q  <= '0;
      sh_vs_q  <= '0;
      sh_vb_q  <= '0;
      rdy_q    <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      sof_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ppl_q    <= ppl_d;
      lpf_q    <= lpf_d;
      fmt_q    <= fmt_d;
      ht_q     <= ht_d;
      hs_q     <= hs_d;
      hb_q     <= hb_d;
      vt_q     <= vt_d;
      vs_q     <= vs_d;
      vb_q     <= vb_d;
      sh_fmt_q <= sh_fmt_d;
      sh_ht_q  <= sh_ht_d;
      sh_hs_q  <= sh_hs_d;
      sh_hb_q  <= sh_hb_d;
      sh_vt_q  <= sh_vt_d;
      sh_vs_q  <= sh_vs_d;
      sh_vb_q  <= sh_vb_d;
      rdy_q    <= rdy_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      sof_q    <= sof_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign fmt_req_rdy = rdy_q;
  assign fmt_def     = fmt_q;
  assign ppl         = ppl_q;
  assign lpf         = lpf_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign sof         = sof_q;
  assign fmt_ack     = ack_q;
  assign fmt_err     = err_q;

endmodule

// File: tb/tb_hdmi_vtc_ctrl.sv
// Directed bench for hdmi_vtc_ctrl: bring-up, wrap, deferred and frame-end switches,
// rejected requests and reset while a switch is pending.
module tb_hdmi_vtc_ctrl;

  logic        clk, rst_n, fmt_req_vld, fmt_req_rdy;
  logic [2:0]  fmt_req, fmt_def;
  logic [11:0] h_total, h_sync, h_blank, v_total, v_sync, v_blank;
  logic [11:0] ppl, lpf;
  logic        hsync, vsync, de, sof, fmt_ack, fmt_err;

  int checks = 0;
  int errors = 0;

  hdmi_vtc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fmt_req_vld (fmt_req_vld),
    .fmt_req_rdy (fmt_req_rdy),
    .fmt_req     (fmt_req),
    .h_total     (h_total),
    .h_sync      (h_sync),
    .h_blank     (h_blank),
    .v_total     (v_total),
    .v_sync      (v_sync),
    .v_blank     (v_blank),
    .fmt_def     (fmt_def),
    .ppl         (ppl),
    .lpf         (lpf),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .sof         (sof),
    .fmt_ack     (fmt_ack),
    .fmt_err     (fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d",
             checks, errors);
    $fatal(1, "timeout");
  end

  task automatic set_fmt(input logic [2:0] f, input logic [11:0] ht, input logic [11:0] hs,
                         input logic [11:0] hb, input logic [11:0] vt, input logic [11:0] vs,
                         input logic [11:0] vb);
    fmt_req = f;
    h_total = ht;
    h_sync  = hs;
    h_blank = hb;
    v_total = vt;
    v_sync  = vs;
    v_blank = vb;
  endtask

  // Advance on negedges until the counters show (p,l); an exhausted budget counts as an error.
  task automatic wait_pos(input logic [11:0] p, input logic [11:0] l, input int budget,
                          input string tag);
    int n = 0;
    while (!(ppl == p && lpf == l) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(ppl === p && lpf === l)) begin
      errors++;
      $display("FAIL %s: position got ppl=%0d lpf=%0d, required ppl=%0d lpf=%0d",
               tag, ppl, lpf, p, l);
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    fmt_req_vld = 1'b0;
    set_fmt(3'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    repeat (2) @(negedge clk);
    checks++;
    if ({ppl, lpf, fmt_def} !== 27'd0) begin
      errors++;
      $display("FAIL reset_counters: got ppl=%0d lpf=%0d fmt_def=%0d, required 0 0 0",
               ppl, lpf, fmt_def);
    end
    checks++;
    if ({hsync, vsync, de, sof, fmt_ack, fmt_err, fmt_req_rdy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 0000000",
               {hsync, vsync, de, sof, fmt_ack, fmt_err, fmt_req_rdy});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (fmt_req_rdy !== 1'b1 || ppl !== 12'd0) begin
      errors++;
      $display("FAIL idle_ready: got rdy=%b ppl=%0d, required rdy=1 ppl=0", fmt_req_rdy, ppl);
    end
  endtask

  task automatic test_bringup;
    int          de_cnt = 0;
    logic [27:0] got, exp;
    logic [11:0] ep, el;
    set_fmt(3'd3, 12'd10, 12'd2, 12'd4, 12'd6, 12'd1, 12'd2);
    fmt_req_vld = 1'b1;
    @(negedge clk);
    fmt_req_vld = 1'b0;
    checks++;
    if (ppl !== 12'd1 || lpf !== 12'd1 || fmt_def !== 3'd3) begin
      errors++;
      $display("FAIL bringup_pos: got ppl=%0d lpf=%0d fmt=%0d, required 1 1 3", ppl, lpf, fmt_def);
    end
    checks++;
    if ({fmt_ack, sof, hsync, vsync, de} !== 5'b11110) begin
      errors++;
      $display("FAIL bringup_strobes: got %b, required 11110", {fmt_ack, sof, hsync, vsync, de});
    end
    for (int i = 0; i < 60; i++) begin
      ep  = 12'(i % 10 + 1);
      el  = 12'(i / 10 + 1);
      exp = {ep, el, ep <= 12'd2, el <= 12'd1, (ep > 12'd4) && (el > 12'd2),
             (ep == 12'd1) && (el == 12'd1)};
      got = {ppl, lpf, hsync, vsync, de, sof};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL frame_a_cycle%0d: got %h, required %h", i, got, exp);
      end
      if (de === 1'b1) de_cnt++;
      @(negedge clk);
    end
    checks++;
    if (de_cnt != 24) begin
      errors++;
      $display("FAIL de_count: got %0d, required 24", de_cnt);
    end
  endtask

  task automatic test_wrap;
    checks++;
    if ({ppl, lpf} !== {12'd1, 12'd1} || sof !== 1'b1 || fmt_ack !== 1'b0) begin
      errors++;
      $display("FAIL wrap_first: got ppl=%0d lpf=%0d sof=%b ack=%b, required 1 1 1 0",
               ppl, lpf, sof, fmt_ack);
    end
    wait_pos(12'd10, 12'd6, 70, "wrap_reach_end");
    checks++;
    if ({hsync, vsync, de, sof} !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_last_strobes: got %b, required 0010", {hsync, vsync, de, sof});
    end
    @(negedge clk);
    checks++;
    if ({ppl, lpf} !== {12'd1, 12'd1} || {sof, vsync, hsync} !== 3'b111) begin
      errors++;
      $display("FAIL wrap_next: got ppl=%0d lpf=%0d sof/vs/hs=%b, required 1 1 111",
               ppl, lpf, {sof, vsync, hsync});
    end
  endtask

  task automatic test_frame_end_req;
    wait_pos(12'd10, 12'd6, 70, "fe_reach_end");
    set_fmt(3'd2, 12'd10, 12'd2, 12'd4, 12'd6, 12'd1, 12'd2);
    fmt_req_vld = 1'b1;
    @(negedge clk);
    fmt_req_vld = 1'b0;
    checks++;
    if ({ppl, lpf} !== {12'd1, 12'd1} || fmt_def !== 3'd3 || fmt_ack !== 1'b0 ||
        fmt_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL fe_old_frame: got ppl=%0d lpf=%0d fmt=%0d ack=%b rdy=%b, required 1 1 3 0 0",
               ppl, lpf, fmt_def, fmt_ack, fmt_req_rdy);
    end
    repeat (59) @(negedge clk);
    checks++;
    if ({ppl, lpf} !== {12'd10, 12'd6} || fmt_def !== 3'd3 || fmt_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL fe_old_end: got ppl=%0d lpf=%0d fmt=%0d rdy=%b, required 10 6 3 0",
               ppl, lpf, fmt_def, fmt_req_rdy);
    end
    @(negedge clk);
    checks++;
    if ({ppl, lpf} !== {12'd1, 12'd1} || fmt_def !== 3'd2 || fmt_ack !== 1'b1 ||
        fmt_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL fe_apply: got ppl=%0d lpf=%0d fmt=%0d ack=%b rdy=%b, required 1 1 2 1 1",
               ppl, lpf, fmt_def, fmt_ack, fmt_req_rdy);
    end
  endtask

  task automatic test_deferred;
    wait_pos(12'd3, 12'd2, 30, "def_reach_start");
    set_fmt(3'd5, 12'd12, 12'd2, 12'd4, 12'd6, 12'd1, 12'd2);
    fmt_req_vld = 1'b1;
    @(negedge clk);
    fmt_req_vld = 1'b0;
    checks++;
    if (fmt_req_rdy !== 1'b0 || fmt_def !== 3'd2 || {ppl, lpf} !== {12'd4, 12'd2}) begin
      errors++;
      $display("FAIL def_accept: got rdy=%b fmt=%0d ppl=%0d lpf=%0d, required 0 2 4 2",
               fmt_req_rdy, fmt_def, ppl, lpf);
    end
    wait_pos(12'd10, 12'd6, 80, "def_old_end");
    checks++;
    if (fmt_def !== 3'd2 || fmt_ack !== 1'b0) begin
      errors++;
      $display("FAIL def_old_fmt: got fmt=%0d ack=%b, required 2 0", fmt_def, fmt_ack);
    end
    @(negedge clk);
    checks++;
    if ({ppl, lpf} !== {12'd1, 12'd1} || fmt_def !== 3'd5 || {fmt_ack, sof, fmt_req_rdy} !== 3'b111)
    begin
      errors++;
      $display("FAIL def_apply: got ppl=%0d lpf=%0d fmt=%0d ack/sof/rdy=%b, required 1 1 5 111",
               ppl, lpf, fmt_def, {fmt_ack, sof, fmt_req_rdy});
    end
    repeat (11) @(negedge clk);
    checks++;
    if ({ppl, lpf} !== {12'd12, 12'd1} || de !== 1'b0 || fmt_ack !== 1'b0) begin
      errors++;
      $display("FAIL def_long_line: got ppl=%0d lpf=%0d de=%b ack=%b, required 12 1 0 0",
               ppl, lpf, de, fmt_ack);
    end
    @(negedge clk);
    checks++;
    if ({ppl, lpf} !== {12'd1, 12'd2}) begin
      errors++;
      $display("FAIL def_line_wrap: got ppl=%0d lpf=%0d, required 1 2", ppl, lpf);
    end
  endtask

  task automatic test_invalid;
    set_fmt(3'd4, 12'd10, 12'd2, 12'd10, 12'd6, 12'd1, 12'd2);
    fmt_req_vld = 1'b1;
    @(negedge clk);
    fmt_req_vld = 1'b0;
    checks++;
    if (fmt_err !== 1'b1 || fmt_ack !== 1'b0) begin
      errors++;
      $display("FAIL inv_err_pulse: got err=%b ack=%b, required 1 0", fmt_err, fmt_ack);
    end
    checks++;
    if (fmt_def !== 3'd5 || fmt_req_rdy !== 1'b1 || {ppl, lpf} !== {12'd2, 12'd2}) begin
      errors++;
      $display("FAIL inv_state: got fmt=%0d rdy=%b ppl=%0d lpf=%0d, required 5 1 2 2",
               fmt_def, fmt_req_rdy, ppl, lpf);
    end
    @(negedge clk);
    checks++;
    if (fmt_err !== 1'b0 || ppl !== 12'd3) begin
      errors++;
      $display("FAIL inv_err_once: got err=%b ppl=%0d, required 0 3", fmt_err, ppl);
    end
    wait_pos(12'd12, 12'd2, 20, "inv_old_timing");
    @(negedge clk);
    checks++;
    if ({ppl, lpf} !== {12'd1, 12'd3} || fmt_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL inv_continue: got ppl=%0d lpf=%0d rdy=%b, required 1 3 1",
               ppl, lpf, fmt_req_rdy);
    end
  endtask

  task automatic test_reset_mid;
    logic moved = 1'b0;
    set_fmt(3'd6, 12'd10, 12'd2, 12'd4, 12'd6, 12'd1, 12'd2);
    fmt_req_vld = 1'b1;
    @(negedge clk);
    fmt_req_vld = 1'b0;
    checks++;
    if (fmt_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend_entry: got rdy=%b, required 0", fmt_req_rdy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({ppl, lpf, fmt_def} !== 27'd0 ||
        {hsync, vsync, de, sof, fmt_ack, fmt_err, fmt_req_rdy} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid_values: got ppl=%0d lpf=%0d fmt=%0d flags=%b, required all 0",
               ppl, lpf, fmt_def, {hsync, vsync, de, sof, fmt_ack, fmt_err, fmt_req_rdy});
    end
    @(negedge clk);
    checks++;
    if (fmt_req_rdy !== 1'b1 || ppl !== 12'd0) begin
      errors++;
      $display("FAIL rst_mid_idle: got rdy=%b ppl=%0d, required 1 0", fmt_req_rdy, ppl);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ppl !== 12'd0 || fmt_def !== 3'd0 || fmt_ack !== 1'b0 || sof !== 1'b0) moved = 1'b1;
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard_shadow: got activity in idle, required none");
    end
    set_fmt(3'd1, 12'd10, 12'd2, 12'd4, 12'd6, 12'd1, 12'd2);
    fmt_req_vld = 1'b1;
    @(negedge clk);
    fmt_req_vld = 1'b0;
    checks++;
    if (fmt_def !== 3'd1 || {ppl, lpf} !== {12'd1, 12'd1} || fmt_ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_new_req: got fmt=%0d ppl=%0d lpf=%0d ack=%b, required 1 1 1 1",
               fmt_def, ppl, lpf, fmt_ack);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_wrap();
    test_frame_end_req();
    test_deferred();
    test_invalid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_vtc_ctrl.md
# hdmi_vtc_ctrl

Video timing controller that sequences the HDMI test-pattern datapath. It generates the free-running pixel-per-line (`ppl`) and line-per-frame (`lpf`) counters, the sync and data-enable strobes, and the active format code `fmt_def`. These feed the pattern generator and the HDMI encoder. Format changes are requested through a valid/ready handshake and take effect only on a frame boundary, so no torn frame is ever emitted.

## Interface
Parameters: none. Counter width is fixed at 12 bits.

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset; synchronous, active-low
- `fmt_req_vld`  in  1  format change request valid
- `fmt_req_rdy`  out  1  controller can accept a request
- `fmt_req`  in  3  requested format code
- `h_total`  in  12  pixels per line, including blanking
- `h_sync`  in  12  last pixel index of hsync
- `h_blank`  in  12  last pixel index of horizontal blanking
- `v_total`  in  12  lines per frame, including blanking
- `v_sync`  in  12  last line index of vsync
- `v_blank`  in  12  last line index of vertical blanking
- `fmt_def`  out  3  format currently driving the counters
- `ppl`  out  12  pixel index, 1-based
- `lpf`  out  12  line index, 1-based
- `hsync`  out  1  active-high horizontal sync
- `vsync`  out  1  active-high vertical sync
- `de`  out  1  active video
- `sof`  out  1  first pixel of frame
- `fmt_ack`  out  1  one-cycle pulse on the first pixel of a newly applied format
- `fmt_err`  out  1  one-cycle pulse when a request is rejected

## Operation
- The six timing inputs are sampled only on request acceptance (`fmt_req_vld && fmt_req_rdy`), into shadow registers.
- Validity check, applied on the accept cycle:
  - `h_total > h_blank`
  - `v_total > v_blank`
  - `h_sync <= h_blank`
  - `v_sync <= v_blank`
  - `h_sync >= 1` and `v_sync >= 1`
- An invalid request is consumed: `fmt_err` pulses on the next cycle and there is no state change.
- States:
  - IDLE: counters held at 0; `fmt_req_rdy=1`. A valid accept goes to RUN, and the new format is applied on the next cycle.
  - RUN: counters advance; `fmt_req_rdy=1`. A valid accept goes to PEND.
  - PEND: counters advance on the old timing; `fmt_req_rdy=0`. At the frame-end cycle (`ppl==h_total && lpf==v_total`) the shadow is applied and the state goes to RUN.
- Apply: active timing and `fmt_def` are loaded from the shadow; `ppl`/`lpf` become 1/1; `fmt_ack=1` on that same cycle.
- Counting in RUN/PEND:
  - `ppl` increments each cycle.
  - When `ppl==h_total`: `ppl` goes to 1 and `lpf` increments.
  - When additionally `lpf==v_total`: `lpf` goes to 1.
- Strobes, all functions of the current `ppl`/`lpf` and active timing:
  - `hsync = ppl<=h_sync`
  - `vsync = lpf<=v_sync`
  - `de = ppl>h_blank && lpf>v_blank`
  - `sof = ppl==1 && lpf==1`
  - All are forced to 0 in IDLE.
- Comparisons are 12-bit unsigned.

## Timing
- Reset values (the cycle after `rst_n` is sampled low): state IDLE, `ppl=0`, `lpf=0`, `fmt_def=0`; `hsync`, `vsync`, `de`, `sof`, `fmt_ack`, `fmt_err` all 0; `fmt_req_rdy=0`.
- After reset: `fmt_req_rdy=1` from the first cycle `rst_n` is sampled high.
- All outputs are registered. Strobes are computed from next-state counter values, so they align with `ppl`/`lpf` in the same cycle (zero relative latency).
- Accept in IDLE at cycle N: at N+1, `ppl=1`, `lpf=1`, `fmt_ack=1`, `sof=1`.
- Accept in RUN on the frame-end cycle itself: the wrap on that cycle uses the old timing. The switch occurs at the following frame end.
- Frame-to-frame transition: no gap cycles. The last pixel of the old format is immediately followed by pixel 1/1 of the new format.
- `fmt_req_rdy` drops the cycle after an accept in RUN and returns on the apply cycle. Back-to-back requests are therefore possible, one per frame.
- An invalid request in RUN leaves the state in RUN and `fmt_req_rdy` stays 1.
- Reset mid-operation: immediate return to reset values; any pending shadow is discarded.

## Test plan
Format A: `h_total=10`, `h_sync=2`, `h_blank=4`, `v_total=6`, `v_sync=1`, `v_blank=2`, `fmt_req=3`.
- **Bring-up:** release reset, request A in IDLE.
  - Next cycle: `ppl=1`, `lpf=1`, `fmt_def=3`, `fmt_ack=1`, `sof=1`, `hsync=1`, `vsync=1`, `de=0`.
  - Frame length is 60 cycles.
  - `de` is high for 24 cycles per frame, covering `ppl` 5..10 on `lpf` 3..6.
- **Counter wrap:** at `ppl=10`, `lpf=6`, the next cycle is `ppl=1`, `lpf=1`, `sof=1`.
  - `hsync` is high exactly for `ppl` 1..2 on every line.
  - `vsync` is high for all of line 1.
- **Deferred switch:** in RUN at `ppl=3`, `lpf=2`, request format 5 with `h_total=12` (other fields as A).
  - `fmt_req_rdy` goes 0.
  - The old frame completes at `ppl=10`, `lpf=6`.
  - Next cycle: `fmt_def=5`, `fmt_ack=1`, `ppl=1`, `lpf=1`.
  - Subsequent lines reach `ppl=12`.
- **Request on frame end:** request format 2 on the cycle `ppl=10`, `lpf=6`.
  - The following frame still runs format 3.
  - The switch happens one full frame (60 cycles) later.
- **Invalid request:** request with `h_blank=10`, `h_total=10` while in RUN.
  - `fmt_err` pulses once.
  - `fmt_def`, counters and `fmt_req_rdy=1` are unchanged.
- **Reset mid-frame:** assert `rst_n=0` for 1 cycle while in PEND.
  - All outputs return to reset values.
  - The pending format is never applied; IDLE waits for a new request.
